// File: rtl/canny_accel_div_seq_32s_14ns_17.sv
// Sequential radix-2 restoring divider: signed dividend / unsigned divisor -> saturated signed quotient.
// Optional half-away-from-zero rounding of the quotient when CANNY_DIV_ROUND_EN is defined.
module canny_accel_div_seq_32s_14ns_17 #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 14,
  parameter int QUOT_W     = 17
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic        [DIVISOR_W-1:0]  divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [QUOT_W-1:0]     quotient,
  output logic signed [DIVISOR_W:0]    remainder,
  output logic                         overflow,
  output logic                         div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W:0] POS_LIM   = {{(DIVIDEND_W + 2 - QUOT_W){1'b0}}, {(QUOT_W - 1){1'b1}}};
  localparam logic [DIVIDEND_W:0] NEG_LIM   = POS_LIM + 1'b1;
  localparam logic [QUOT_W-1:0]   Q_MAX     = {1'b0, {(QUOT_W - 1){1'b1}}};
  localparam logic [QUOT_W-1:0]   Q_MIN     = {1'b1, {(QUOT_W - 1){1'b0}}};

  state_t                 state_reg;
  logic [DIVIDEND_W-1:0]  work_reg;
  logic [DIVISOR_W:0]     rem_reg;
  logic [DIVISOR_W-1:0]   dvs_reg;
  logic                   neg_reg;
  logic [CNT_W-1:0]       cnt_reg;

  // Magnitude of the most negative dividend is still representable unsigned.
  logic [DIVIDEND_W-1:0]  dividend_mag;
  assign dividend_mag = dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;

  // work_reg shifts dividend bits out of the top and quotient bits in at the bottom.
  logic [DIVISOR_W:0] trial;
  logic               trial_ge;
  logic [DIVISOR_W:0] rem_next;
  assign trial    = {rem_reg[DIVISOR_W-1:0], work_reg[DIVIDEND_W-1]};
  assign trial_ge = (trial >= {1'b0, dvs_reg});
  assign rem_next = trial_ge ? (trial - {1'b0, dvs_reg}) : trial;

  logic [DIVIDEND_W:0] qmag;
`ifdef CANNY_DIV_ROUND_EN
  logic round_up;
  assign round_up = ({rem_reg, 1'b0} >= {2'b00, dvs_reg});
  assign qmag     = {1'b0, work_reg} + {{DIVIDEND_W{1'b0}}, round_up};
`else
  assign qmag = {1'b0, work_reg};
`endif

  logic [QUOT_W-1:0]  q_fix;
  logic               ovf_fix;
  logic [DIVISOR_W:0] r_fix;
  always_comb begin
    q_fix   = '0;
    ovf_fix = 1'b0;
    if (!neg_reg) begin
      if (qmag > POS_LIM) begin
        q_fix   = Q_MAX;
        ovf_fix = 1'b1;
      end else begin
        q_fix = qmag[QUOT_W-1:0];
      end
    end else begin
      if (qmag > NEG_LIM) begin
        q_fix   = Q_MIN;
        ovf_fix = 1'b1;
      end else begin
        q_fix = ~qmag[QUOT_W-1:0] + 1'b1;
      end
    end
    r_fix = neg_reg ? (~rem_reg + 1'b1) : rem_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      work_reg    <= '0;
      rem_reg     <= '0;
      dvs_reg     <= '0;
      neg_reg     <= 1'b0;
      cnt_reg     <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg  <= dividend_mag;
            neg_reg   <= dividend[DIVIDEND_W-1];
            dvs_reg   <= divisor;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            in_ready  <= 1'b0;
            state_reg <= (divisor != '0) ? CALC : FIXUP;
          end
        end
        CALC: begin
          work_reg <= {work_reg[DIVIDEND_W-2:0], trial_ge};
          rem_reg  <= rem_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_ITER) state_reg <= FIXUP;
        end
        FIXUP: begin
          if (dvs_reg == '0) begin
            quotient    <= neg_reg ? Q_MIN : Q_MAX;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            overflow    <= ovf_fix;
            div_by_zero <= 1'b0;
          end
          out_valid <= 1'b1;
          state_reg <= DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_canny_accel_div_seq_32s_14ns_17.sv
// Directed-vector bench for the sequential divider; expected values hand-computed, with
// alternate columns used when CANNY_DIV_ROUND_EN is defined.
module tb_canny_accel_div_seq_32s_14ns_17;

  logic               clk;
  logic               rst_n;
  logic               ce;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] dividend;
  logic [13:0]        divisor;
  logic               out_valid;
  logic               out_ready;
  logic signed [16:0] quotient;
  logic signed [14:0] remainder;
  logic               overflow;
  logic               div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef CANNY_DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  canny_accel_div_seq_32s_14ns_17 dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] dvd;
    logic [13:0]        dvs;
    int                 q;
    int                 r;
    bit                 ovf;
    bit                 dbz;
    int                 q_rnd;
    bit                 ovf_rnd;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Latency is counted in rising edges with the accept edge as edge 1.
  task automatic run_div(input logic signed [31:0] a, input logic [13:0] b,
                         input int ce_at, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", int'(in_ready), 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (lat == ce_at)     ce = 1'b0;
      if (lat == ce_at + 5) ce = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    ce = 1'b1;
    chk("out_valid_within_bound", int'(lat < 200), 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_consume", int'(out_valid), 0);
    chk("in_ready_after_consume", int'(in_ready), 1);
  endtask

  vec_t vecs[17];
  int   lat;
  int   exp_q;
  bit   exp_ovf;

  initial begin
    vecs[0]  = '{32'sd1000,        14'd7,     142,    6,      1'b0, 1'b0, 143,    1'b0};
    vecs[1]  = '{-32'sd1000,       14'd7,     -142,   -6,     1'b0, 1'b0, -143,   1'b0};
    vecs[2]  = '{32'sd2147483647,  14'd1,     65535,  0,      1'b1, 1'b0, 65535,  1'b1};
    vecs[3]  = '{32'h80000000,     14'd16383, -65536, -8,     1'b1, 1'b0, -65536, 1'b1};
    vecs[4]  = '{-32'sd65536,      14'd1,     -65536, 0,      1'b0, 1'b0, -65536, 1'b0};
    vecs[5]  = '{32'sd5,           14'd0,     65535,  0,      1'b0, 1'b1, 65535,  1'b0};
    vecs[6]  = '{-32'sd5,          14'd0,     -65536, 0,      1'b0, 1'b1, -65536, 1'b0};
    vecs[7]  = '{32'sd100,         14'd3,     33,     1,      1'b0, 1'b0, 33,     1'b0};
    vecs[8]  = '{32'sd0,           14'd5,     0,      0,      1'b0, 1'b0, 0,      1'b0};
    vecs[9]  = '{32'sd65536,       14'd1,     65535,  0,      1'b1, 1'b0, 65535,  1'b1};
    vecs[10] = '{-32'sd65537,      14'd1,     -65536, 0,      1'b1, 1'b0, -65536, 1'b1};
    vecs[11] = '{32'sd12345,       14'd16383, 0,      12345,  1'b0, 1'b0, 1,      1'b0};
    vecs[12] = '{-32'sd12345,      14'd16383, 0,      -12345, 1'b0, 1'b0, -1,     1'b0};
    vecs[13] = '{32'sd7,           14'd2,     3,      1,      1'b0, 1'b0, 4,      1'b0};
    vecs[14] = '{-32'sd7,          14'd2,     -3,     -1,     1'b0, 1'b0, -4,     1'b0};
    vecs[15] = '{32'sd1048575,     14'd16,    65535,  15,     1'b0, 1'b0, 65535,  1'b1};
    vecs[16] = '{32'sd2147483647,  14'd16383, 65535,  7,      1'b1, 1'b0, 65535,  1'b1};

    rst_n = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_flags", int'({overflow, div_by_zero}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      exp_q   = ROUND ? vecs[i].q_rnd : vecs[i].q;
      exp_ovf = ROUND ? vecs[i].ovf_rnd : vecs[i].ovf;
      run_div(vecs[i].dvd, vecs[i].dvs, -10, lat);
      $display("vec %0d: %0d / %0d -> q=%0d r=%0d ovf=%0b dbz=%0b lat=%0d", i,
               vecs[i].dvd, vecs[i].dvs, quotient, remainder, overflow, div_by_zero, lat);
      chk($sformatf("vec%0d_quotient", i), int'(quotient), exp_q);
      chk($sformatf("vec%0d_remainder", i), int'(remainder), vecs[i].r);
      chk($sformatf("vec%0d_overflow", i), int'(overflow), int'(exp_ovf));
      chk($sformatf("vec%0d_div_by_zero", i), int'(div_by_zero), int'(vecs[i].dbz));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].dvs == 0 ? 2 : 34);
      chk($sformatf("vec%0d_in_ready_done", i), int'(in_ready), 0);
      consume();
    end

    // Backpressure: hold the result for 10 cycles.
    run_div(32'sd1000, 14'd7, -10, lat);
    exp_q = ROUND ? 143 : 142;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_quotient", int'(quotient), exp_q);
      chk("hold_remainder", int'(remainder), 6);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    $display("backpressure: q=%0d r=%0d held 10 cycles", quotient, remainder);
    consume();

    // Clock-enable low for 5 cycles mid-calculation.
    run_div(-32'sd1000, 14'd7, 10, lat);
    $display("ce drop: q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    chk("ce_latency", lat, 39);
    chk("ce_quotient", int'(quotient), ROUND ? -143 : -142);
    chk("ce_remainder", int'(remainder), -6);
    consume();

    // Asynchronous reset at iteration 16.
    @(negedge clk);
    dividend = 32'sd2147483647; divisor = 14'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("busy_in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_flags", int'({overflow, div_by_zero}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div(32'sd100, 14'd3, -10, lat);
    $display("after reset: 100 / 3 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    chk("postrst_quotient", int'(quotient), 33);
    chk("postrst_remainder", int'(remainder), 1);
    chk("postrst_latency", lat, 34);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/canny_accel_div_seq_32s_14ns_17.md
Name: canny_accel_div_seq_32s_14ns_17

Overview:
- Iterative signed/unsigned divider. It is the inverse of the 17s x 14ns -> 32 multiply path in the Canny accelerator.
- Recovers a 17-bit signed quotient from a 32-bit signed product-domain value and a 14-bit unsigned scale.
- Used for gradient de-normalisation and threshold rescaling after fixed-point scaling.
- Radix-2 restoring core with valid/ready handshakes on both sides. One division in flight.

Parameters:
- DIVIDEND_W, 32, signed dividend width.
- DIVISOR_W, 14, unsigned divisor width.
- QUOT_W, 17, signed quotient width; result saturates to this range.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; low freezes all state and outputs.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  DIVIDEND_W  signed dividend.
- divisor  in  DIVISOR_W  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  QUOT_W  signed quotient, saturated.
- remainder  out  DIVISOR_W+1  signed remainder; sign follows the dividend.
- overflow  out  1  quotient was saturated.
- div_by_zero  out  1  divisor was 0.

Behaviour:
- Reset values: in_ready=1; out_valid=0; quotient, remainder, overflow and div_by_zero = 0; state=IDLE.
- States: IDLE, CALC, FIXUP, DONE.
- in_ready = (state==IDLE). Registered, with no combinational path from out_ready.
- Accept: ce & in_valid & in_ready at edge N. Latch |dividend| (DIVIDEND_W-bit unsigned), the dividend sign, and the divisor. Clear the iteration counter.
  - divisor!=0 -> CALC.
  - divisor==0 -> FIXUP directly.
- CALC: one quotient bit per ce cycle, MSB first. Partial remainder is DIVISOR_W+1 bits. After DIVIDEND_W iterations -> FIXUP.
- FIXUP (one cycle):
  - Apply the sign.
  - Quotient truncates toward zero; remainder = sign(dividend) x magnitude remainder.
  - Saturate: if the signed quotient is outside [-2^(QUOT_W-1), 2^(QUOT_W-1)-1], clamp to the nearest bound and set overflow=1.
  - If divisor==0: quotient = +max for dividend>=0, -min otherwise; remainder=0; div_by_zero=1; overflow=0.
  - Register results and go to DONE.
- DONE: out_valid=1; outputs stable. On ce & out_ready -> IDLE, out_valid=0, in_ready=1 after that edge.
- Latency with ce held high: out_valid rises DIVIDEND_W+2 edges after the accept edge (34 at defaults). With divisor==0 it rises 2 edges after accept. Each ce-low cycle adds one cycle.
- Throughput: one result per DIVIDEND_W+3 cycles minimum. Accept and output cannot happen in the same cycle.
- Magnitude edge case: dividend = -2^(DIVIDEND_W-1) is handled as unsigned magnitude 2^(DIVIDEND_W-1). No wrap.
- rst_n asserted mid-CALC or mid-DONE: immediate return to reset values. The in-flight result is discarded.
- in_valid while busy is ignored (in_ready=0). The source must hold its operands.

Optional Feature:
- Macro: CANNY_DIV_ROUND_EN.
- Defined: FIXUP rounds half away from zero. If 2 x |rem| >= divisor, the magnitude quotient is incremented before the sign is applied and before saturation. The remainder output is still the unrounded truncating remainder. Latency is unchanged.
- Undefined: truncate toward zero only. No increment logic is synthesised.

Test Plan:
- Basic truncation: dividend=1000, divisor=7 -> quotient=142, remainder=6, overflow=0. Under ROUND_EN -> quotient=143, remainder=6.
- Negative dividend: dividend=-1000, divisor=7 -> quotient=-142, remainder=-6. Under ROUND_EN -> quotient=-143. out_valid rises exactly 34 edges after accept.
- Saturation and extreme operands:
  - 2147483647/1 -> quotient=65535, overflow=1.
  - -2147483648/16383 -> quotient=-65536, overflow=1.
  - -65536/1 -> quotient=-65536, overflow=0.
- Divide by zero: 5/0 -> quotient=65535, remainder=0, div_by_zero=1, 2-cycle latency. -5/0 -> quotient=-65536.
- Backpressure and ce:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
  - Release -> in_ready=1 on the next edge.
  - Drop ce for 5 cycles mid-CALC -> latency becomes 39 with the same result.
- Reset mid-operation: assert rst_n=0 at iteration 16 -> all outputs 0 and in_ready=1 immediately. A subsequent 100/3 -> quotient=33, remainder=1.
